sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 5, SHALL set the number of SRAM access cycles per read or write (legal range 1..15).
REQ-002 Parameter ADDR_BASE, default 1024, SHALL set the CPU byte address that maps to SRAM word 0.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: the reset; it SHALL be asynchronous and active-high.
REQ-005 Port wr_en, input, 1: write request from the MEM stage.
REQ-006 Port rd_en, input, 1: read request from the MEM stage.
REQ-007 Port address, input, 32: CPU byte address.
REQ-008 Port write_data, input, 32: word to write.
REQ-009 Port read_data, output, 32: last word read.
REQ-010 Port ready, output, 1: a low value SHALL freeze the pipeline.
REQ-011 Port SRAM_WE_N, output, 1: active-low SRAM write enable.
REQ-012 Port SRAM_ADDR, output, 17: SRAM word address.
REQ-013 Port SRAM_DQ, inout, 32: the bidirectional SRAM data bus.

Function
REQ-014 The word address SHALL be computed as ((address - ADDR_BASE) >> 2), truncated to 17 bits; no range check is performed.
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE and DONE, and SHALL reset to IDLE.
REQ-016 In IDLE with wr_en=1, the FSM SHALL register the address and write_data and go to WRITE. If rd_en=1 in the same cycle, the write SHALL take priority.
REQ-017 In IDLE with rd_en=1 and wr_en=0, the FSM SHALL register the address and go to READ.
REQ-018 ready SHALL be combinational: 0 when (rd_en|wr_en)=1 and state!=DONE, and 1 otherwise.
REQ-019 In READ and WRITE, the wait counter SHALL count from 0. When the counter equals WAIT_CYCLES-1, the FSM SHALL go to DONE.
REQ-020 In WRITE, SRAM_WE_N SHALL be 0 and SRAM_DQ SHALL be driven with the registered data. In every other state, SRAM_WE_N SHALL be 1 and SRAM_DQ SHALL be high-impedance.
REQ-021 On the READ-to-DONE transition edge, read_data SHALL capture SRAM_DQ. At all other times, read_data SHALL hold its value.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE. A request present in that IDLE cycle SHALL start a new access.
REQ-023 Latency: for a request first seen at cycle 0, ready SHALL be 1 at cycle WAIT_CYCLES+1.
REQ-024 The inputs address, write_data, rd_en and wr_en SHALL be ignored outside IDLE.
REQ-025 SRAM_ADDR SHALL show the registered word address during READ and WRITE, and SHALL hold its last value in all other states.

Reset
REQ-026 Asserting rst SHALL immediately set: state=IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z.
REQ-027 Asserting rst mid-access SHALL abort the access without completing it. After rst is released, the next request SHALL be handled normally.

Configuration
REQ-028 When SRAM_WRITE_BUFFER_EN is defined, a write accepted in IDLE SHALL see ready=1 in that same cycle (posted write).
REQ-029 With SRAM_WRITE_BUFFER_EN defined, a posted write SHALL return from WRITE directly to IDLE, skipping DONE.
REQ-030 With SRAM_WRITE_BUFFER_EN defined, any request arriving while a posted write is in progress SHALL see ready=0 until the write reaches IDLE; the new request SHALL then proceed per REQ-016/017.
REQ-031 When SRAM_WRITE_BUFFER_EN is not defined, writes SHALL behave exactly like reads for handshaking (REQ-018, REQ-022).

Structure
REQ-032 The shared package sram_ctrl_pkg SHALL hold the state enum, the SRAM address width (17), the data width (32) and the ADDR_BASE default.
REQ-033 The wait counter SHALL be implemented as the sub-module sram_wait_counter (clk, rst, start, done), parameterized by WAIT_CYCLES.

Verification (WAIT_CYCLES=5)
REQ-034 Plain write: wr_en=1, address=1028, write_data=0xDEADBEEF at cycle 0 -> SRAM_ADDR=1 and SRAM_WE_N=0 for cycles 1-5, ready=1 at cycle 6; with SRAM_WRITE_BUFFER_EN, ready=1 at cycle 0.
REQ-035 Read-back: after the write above, rd_en=1, address=1028 -> read_data=0xDEADBEEF with ready=1 at cycle 6, and SRAM_DQ=Z throughout the read.
REQ-036 Simultaneous request: rd_en=1 and wr_en=1, address=1024, write_data=0x5 -> a write to SRAM_ADDR=0, and read_data unchanged.
REQ-037 Reset mid-access: rst pulsed at cycle 3 of a read -> state=IDLE, read_data=0, SRAM_WE_N=1 immediately; a repeated read then completes in 6 cycles.
REQ-038 Back-to-back posted writes (SRAM_WRITE_BUFFER_EN): write at cycle 0, second write at cycle 1 -> ready=0 from cycle 1 until the first write completes; both words are present in the SRAM afterwards.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM controller slice.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW           = 17;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // CPU byte address to SRAM word address; out-of-window addresses simply wrap.
  function automatic logic [SRAM_AW-1:0] word_addr(input logic [DATA_W-1:0] byte_addr,
                                                   input logic [DATA_W-1:0] base);
    return SRAM_AW'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side MEM-stage bus of the SRAM controller, with master/slave views.
interface sram_controller_if;
  import sram_ctrl_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Access-cycle counter: counts from 0 while start is held, done on the last cycle.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  logic [3:0] count_q, count_d;

  assign done = start && (count_q == 4'(WAIT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (!start || done) count_d = '0;
    else                count_d = count_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/sram_controller.sv
// Multi-cycle SRAM controller for the MEM stage.
// Define SRAM_WRITE_BUFFER_EN to post writes (ready in the accept cycle, WRITE returns to IDLE).
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [DATA_W-1:0]  address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  logic [DATA_W-1:0]  SRAM_DQ
);

  state_e              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy;
  logic                cnt_done;

  assign busy = (state_q == READ) || (state_q == WRITE);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .start (busy),
    .done  (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_en)      state_d = WRITE;
        else if (rd_en) state_d = READ;
      end
      READ:  if (cnt_done) state_d = DONE;
`ifdef SRAM_WRITE_BUFFER_EN
      WRITE: if (cnt_done) state_d = IDLE;
`else
      WRITE: if (cnt_done) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (wr_en || rd_en)) addr_q <= word_addr(address, DATA_W'(ADDR_BASE));
      if (state_q == IDLE && wr_en)            wdata_q <= write_data;
      if (state_q == READ && cnt_done)         rdata_q <= SRAM_DQ;
    end
  end

  // A posted write is released in its accept cycle; everything else stalls until DONE.
  always_comb begin
    ready = !((rd_en || wr_en) && (state_q != DONE));
`ifdef SRAM_WRITE_BUFFER_EN
    if (state_q == IDLE && wr_en) ready = 1'b1;
`endif
  end

  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = (state_q != WRITE);
  assign SRAM_DQ   = (state_q == WRITE) ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Directed + randomized bench for sram_controller with a transaction-level reference model.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  localparam int unsigned WAIT = 5;
  localparam int unsigned BASE = 1024;
`ifdef SRAM_WRITE_BUFFER_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [31:0] sram_dq;

  int checks   = 0;
  int failures = 0;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(WAIT), .ADDR_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .address    (bus.address),
    .write_data (bus.write_data),
    .read_data  (bus.read_data),
    .ready      (bus.ready),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (sram_dq)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: output enabled whenever not being written.
  logic [31:0] sram_mem [0:131071];
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 'z;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  // Reference model: memory contents and last read word at transaction level.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rd = '0;

  function automatic int unsigned ref_word(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return (off / 4) % 131072;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    int unsigned wa      = ref_word(a);
    bit          is_wr   = wr;
    int unsigned exp_lat = (wr && POSTED) ? 0 : WAIT + 1;
    int unsigned cyc     = 0;
    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    @(negedge clk);
    while (!bus.ready && cyc < 40) begin
      if (cyc >= 1) begin
        chk("sram_addr", 32'(sram_addr), 32'(wa));
        chk("we_n", 32'(sram_we_n), is_wr ? 32'd0 : 32'd1);
        if (is_wr) chk("dq_wdata", sram_dq, d);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    if (is_wr) ref_mem[wa] = d;
    else       ref_rd = ref_mem.exists(wa) ? ref_mem[wa] : 32'd0;
    if (!(is_wr && POSTED)) chk("read_data", bus.read_data, ref_rd);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    if (is_wr && POSTED) repeat (WAIT + 1) @(posedge clk);
    if (is_wr) begin
      @(negedge clk);
      chk("sram_mem", sram_mem[wa], d);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) sram_mem[i] = '0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_read_data", bus.read_data, 32'd0);
    rst = 1'b0;

    // Plain write, read-back, simultaneous request
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1028, 32'd0);
    access(1'b1, 1'b1, 32'd1024, 32'h5);
    access(1'b0, 1'b1, 32'd1024, 32'd0);
    access(1'b0, 1'b1, 32'd1028, 32'd0);

    // Reset at cycle 3 of a read, then the same read again
    @(posedge clk); #1;
    bus.rd_en = 1'b1; bus.address = 32'd1028;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_read_data", bus.read_data, 32'd0);
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
    bus.rd_en = 1'b0;
    ref_rd = '0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b0;
    access(1'b0, 1'b1, 32'd1028, 32'd0);

    // Address window edges: just below base wraps to the top word, far above wraps to 0
    access(1'b1, 1'b0, 32'd1020, 32'hA5A5_0001);
    access(1'b0, 1'b1, 32'd1020, 32'd0);
    access(1'b0, 1'b1, BASE + 32'h0008_0000, 32'd0);

`ifdef SRAM_WRITE_BUFFER_EN
    begin
      int unsigned cyc;
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.address = BASE + 40; bus.write_data = 32'h1111_2222;
      @(negedge clk);
      chk("b2b_ready_c0", 32'(bus.ready), 32'd1);
      @(posedge clk); #1;
      bus.address = BASE + 44; bus.write_data = 32'h3333_4444;
      cyc = 1;
      @(negedge clk);
      while (!bus.ready && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b_stall_cycles", cyc, WAIT + 1);
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      repeat (WAIT + 1) @(posedge clk);
      @(negedge clk);
      ref_mem[ref_word(BASE + 40)] = 32'h1111_2222;
      ref_mem[ref_word(BASE + 44)] = 32'h3333_4444;
      chk("b2b_mem0", sram_mem[ref_word(BASE + 40)], ref_mem[ref_word(BASE + 40)]);
      chk("b2b_mem1", sram_mem[ref_word(BASE + 44)], ref_mem[ref_word(BASE + 44)]);
    end
`endif

    // Randomized traffic over a small window of words
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int unsigned op;
      a  = BASE + 4 * $urandom_range(0, 15);
      op = $urandom_range(0, 3);
      case (op)
        0, 1:    access(1'b0, 1'b1, a, 32'd0);
        2:       access(1'b1, 1'b0, a, $urandom);
        default: access(1'b1, 1'b1, a, $urandom);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
